// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU operation codes as produced by the decode control
// unit, the link register index, and the all-zero control bundle used as a bubble.
package cpu_pkg;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd3;
  localparam logic [4:0] ALU_XOR = 5'd4;
  localparam logic [4:0] ALU_NOR = 5'd5;
  localparam logic [4:0] ALU_SLT = 5'd6;
  localparam logic [4:0] ALU_SLL = 5'd7;
  localparam logic [4:0] ALU_SRL = 5'd8;
  localparam logic [4:0] ALU_SRA = 5'd9;
  localparam logic [4:0] ALU_LUI = 5'd10;

  // Link register written by JAL
  localparam int REG_RA = 31;

  // Control bits that travel from ID into EX
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       is_shift;
    logic       is_jal;
    logic [4:0] alu_control;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-to-EX pipeline bus: decoded ID instruction and pipeline controls in,
// registered EX bundle and stall request out.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
);

  logic              id_valid;
  logic              id_reg_write;
  logic              id_mem_to_reg;
  logic              id_mem_write;
  logic              id_alu_src;
  logic              id_reg_dst_rt;
  logic              id_is_shift;
  logic              id_is_jal;
  logic [4:0]        id_alu_control;
  logic              id_is_branch;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic [RA_W-1:0]   id_rs;
  logic [RA_W-1:0]   id_rt;
  logic [RA_W-1:0]   id_rd;
  logic [4:0]        id_shamt;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;
  logic [DATA_W-1:0] id_pc_plus4;
  logic              hold;
  logic              flush;

  logic              stall;
  logic              ex_valid;
  logic              ex_reg_write;
  logic              ex_mem_to_reg;
  logic              ex_mem_write;
  logic              ex_alu_src;
  logic              ex_is_shift;
  logic              ex_is_jal;
  logic [4:0]        ex_alu_control;
  logic [RA_W-1:0]   ex_rs;
  logic [RA_W-1:0]   ex_rt;
  logic [RA_W-1:0]   ex_write_reg;
  logic [4:0]        ex_shamt;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [DATA_W-1:0] ex_pc_plus4;

  modport master (
    output id_valid, id_reg_write, id_mem_to_reg, id_mem_write, id_alu_src,
           id_reg_dst_rt, id_is_shift, id_is_jal, id_alu_control, id_is_branch,
           id_uses_rs, id_uses_rt, id_rs, id_rt, id_rd, id_shamt, id_rs_data,
           id_rt_data, id_imm, id_pc_plus4, hold, flush,
    input  stall, ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write,
           ex_alu_src, ex_is_shift, ex_is_jal, ex_alu_control, ex_rs, ex_rt,
           ex_write_reg, ex_shamt, ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus4
  );

  modport slave (
    input  id_valid, id_reg_write, id_mem_to_reg, id_mem_write, id_alu_src,
           id_reg_dst_rt, id_is_shift, id_is_jal, id_alu_control, id_is_branch,
           id_uses_rs, id_uses_rt, id_rs, id_rt, id_rd, id_shamt, id_rs_data,
           id_rt_data, id_imm, id_pc_plus4, hold, flush,
    output stall, ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write,
           ex_alu_src, ex_is_shift, ex_is_jal, ex_alu_control, ex_rs, ex_rt,
           ex_write_reg, ex_shamt, ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus4
  );

endinterface

// File: rtl/hazard_detect.sv
// Combinational hazard check of the ID instruction against the instruction
// currently in EX: load-use and branch-in-ID operand dependencies.
module hazard_detect #(
  parameter int RA_W = 5
) (
  input  logic            rst,
  input  logic            id_valid,
  input  logic            flush,
  input  logic            id_uses_rs,
  input  logic            id_uses_rt,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            id_is_branch,
  input  logic            ex_valid,
  input  logic            ex_reg_write,
  input  logic            ex_mem_to_reg,
  input  logic [RA_W-1:0] ex_write_reg,
  output logic            stall
);

  logic dep_rs;
  logic dep_rt;
  logic dep;
  logic load_use;
  logic branch_dep;

  // Register 0 is hardwired, so it never creates a dependency; a flush
  // discards the ID instruction and therefore overrides any hazard.
  always_comb begin
    dep_rs     = id_uses_rs && (id_rs != '0) && (id_rs == ex_write_reg);
    dep_rt     = id_uses_rt && (id_rt != '0) && (id_rt == ex_write_reg);
    dep        = ex_valid && ex_reg_write && (dep_rs || dep_rt);
    load_use   = dep && ex_mem_to_reg;
    branch_dep = dep && id_is_branch;
    stall      = !rst && id_valid && !flush && (load_use || branch_dep);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hazard stall, bubble injection, external hold
// and flush, plus stall/bubble performance counters.
// Limit: a load followed by a branch that reads the loaded register stalls
// here for one cycle only (load_use). The second cycle must come from the
// MEM-stage hazard path outside this block, because the bubble now in EX
// no longer matches the branch operand.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  id_ex_stage_if.slave     bus,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_count
);

  logic              stall;
  logic              load_bubble;

  logic              valid_q,    valid_d;
  ctrl_t             ctrl_q,     ctrl_d;
  logic [RA_W-1:0]   rs_q,       rs_d;
  logic [RA_W-1:0]   rt_q,       rt_d;
  logic [RA_W-1:0]   wr_q,       wr_d;
  logic [4:0]        shamt_q,    shamt_d;
  logic [DATA_W-1:0] rs_data_q,  rs_data_d;
  logic [DATA_W-1:0] rt_data_q,  rt_data_d;
  logic [DATA_W-1:0] imm_q,      imm_d;
  logic [DATA_W-1:0] pc4_q,      pc4_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  function automatic logic [RA_W-1:0] sel_write_reg(
    input logic            is_jal,
    input logic            reg_dst_rt,
    input logic [RA_W-1:0] rt,
    input logic [RA_W-1:0] rd
  );
    if (is_jal)          return RA_W'(REG_RA);
    else if (reg_dst_rt) return rt;
    else                 return rd;
  endfunction

  hazard_detect #(.RA_W(RA_W)) u_hazard (
    .rst          (reset),
    .id_valid     (bus.id_valid),
    .flush        (bus.flush),
    .id_uses_rs   (bus.id_uses_rs),
    .id_uses_rt   (bus.id_uses_rt),
    .id_rs        (bus.id_rs),
    .id_rt        (bus.id_rt),
    .id_is_branch (bus.id_is_branch),
    .ex_valid     (valid_q),
    .ex_reg_write (ctrl_q.reg_write),
    .ex_mem_to_reg(ctrl_q.mem_to_reg),
    .ex_write_reg (wr_q),
    .stall        (stall)
  );

  // Next-state: hold freezes everything; otherwise load a bubble or capture ID
  always_comb begin
    valid_d      = valid_q;
    ctrl_d       = ctrl_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    wr_d         = wr_q;
    shamt_d      = shamt_q;
    rs_data_d    = rs_data_q;
    rt_data_d    = rt_data_q;
    imm_d        = imm_q;
    pc4_d        = pc4_q;
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    load_bubble  = bus.flush || stall || !bus.id_valid;

    if (!bus.hold) begin
      if (load_bubble) begin
        valid_d      = 1'b0;
        ctrl_d       = CTRL_BUBBLE;
        rs_d         = '0;
        rt_d         = '0;
        wr_d         = '0;
        shamt_d      = '0;
        rs_data_d    = '0;
        rt_data_d    = '0;
        imm_d        = '0;
        pc4_d        = '0;
        bubble_cnt_d = bubble_cnt_q + 1'b1;
      end else begin
        valid_d               = 1'b1;
        ctrl_d.reg_write      = bus.id_reg_write;
        ctrl_d.mem_to_reg     = bus.id_mem_to_reg;
        ctrl_d.mem_write      = bus.id_mem_write;
        ctrl_d.alu_src        = bus.id_alu_src;
        ctrl_d.is_shift       = bus.id_is_shift;
        ctrl_d.is_jal         = bus.id_is_jal;
        ctrl_d.alu_control    = bus.id_alu_control;
        rs_d                  = bus.id_rs;
        rt_d                  = bus.id_rt;
        wr_d                  = sel_write_reg(bus.id_is_jal, bus.id_reg_dst_rt,
                                              bus.id_rt, bus.id_rd);
        shamt_d               = bus.id_shamt;
        rs_data_d             = bus.id_rs_data;
        rt_data_d             = bus.id_rt_data;
        imm_d                 = bus.id_imm;
        pc4_d                 = bus.id_pc_plus4;
      end
      if (stall) stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // State register; reset yields a bubble and clears the counters
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      ctrl_q       <= CTRL_BUBBLE;
      rs_q         <= '0;
      rt_q         <= '0;
      wr_q         <= '0;
      shamt_q      <= '0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      pc4_q        <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      ctrl_q       <= ctrl_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      wr_q         <= wr_d;
      shamt_q      <= shamt_d;
      rs_data_q    <= rs_data_d;
      rt_data_q    <= rt_data_d;
      imm_q        <= imm_d;
      pc4_q        <= pc4_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.stall          = stall;
  assign bus.ex_valid       = valid_q;
  assign bus.ex_reg_write   = ctrl_q.reg_write;
  assign bus.ex_mem_to_reg  = ctrl_q.mem_to_reg;
  assign bus.ex_mem_write   = ctrl_q.mem_write;
  assign bus.ex_alu_src     = ctrl_q.alu_src;
  assign bus.ex_is_shift    = ctrl_q.is_shift;
  assign bus.ex_is_jal      = ctrl_q.is_jal;
  assign bus.ex_alu_control = ctrl_q.alu_control;
  assign bus.ex_rs          = rs_q;
  assign bus.ex_rt          = rt_q;
  assign bus.ex_write_reg   = wr_q;
  assign bus.ex_shamt       = shamt_q;
  assign bus.ex_rs_data     = rs_data_q;
  assign bus.ex_rt_data     = rt_data_q;
  assign bus.ex_imm         = imm_q;
  assign bus.ex_pc_plus4    = pc4_q;
  assign stall_cycles       = stall_cnt_q;
  assign bubble_count       = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: table of hazard vectors, hand sequences for the
// multi-cycle cases, and a random run against a behavioural model.
module tb_id_ex_stage;
  import cpu_pkg::*;

  typedef struct packed {
    logic        valid, reg_write, mem_to_reg, mem_write, alu_src, reg_dst_rt, is_shift, is_jal;
    logic [4:0]  alu_control;
    logic        is_branch, uses_rs, uses_rt;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] rs_data, rt_data, imm, pc4;
  } id_t;

  typedef struct packed {
    logic        valid, reg_write, mem_to_reg, mem_write, alu_src, is_shift, is_jal;
    logic [4:0]  alu_control, rs, rt, wr, shamt;
    logic [31:0] rs_data, rt_data, imm, pc4;
  } ex_t;

  typedef struct {
    id_t        ex_in;
    id_t        id_in;
    bit         flush;
    bit         exp_stall;
    logic [4:0] exp_wr;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [31:0] stall_cycles;
  logic [31:0] bubble_count;

  id_ex_stage_if #(.DATA_W(32), .RA_W(5)) ifc ();

  id_ex_stage #(.DATA_W(32), .RA_W(5), .CNT_W(32)) dut (
    .clk          (clk),
    .reset        (rst),
    .bus          (ifc),
    .stall_cycles (stall_cycles),
    .bubble_count (bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  id_t         cur;
  logic        rst_i, hold_i, flush_i;
  ex_t         m_ex;
  logic [31:0] m_stall_cnt, m_bub_cnt;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic id_t mk(input bit rw, input bit m2r, input bit br, input bit urs,
                             input bit urt, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input bit dst_rt, input bit jal);
    id_t t;
    t             = '0;
    t.valid       = 1'b1;
    t.reg_write   = rw;
    t.mem_to_reg  = m2r;
    t.alu_src     = dst_rt;
    t.reg_dst_rt  = dst_rt;
    t.is_jal      = jal;
    t.alu_control = br ? ALU_SUB : ALU_ADD;
    t.is_branch   = br;
    t.uses_rs     = urs;
    t.uses_rt     = urt;
    t.rs          = rs;
    t.rt          = rt;
    t.rd          = rd;
    t.shamt       = 5'd3;
    t.rs_data     = 32'h1000_0000 | 32'(rs);
    t.rt_data     = 32'h2000_0000 | 32'(rt);
    t.imm         = 32'hFFFF_FFF0;
    t.pc4         = 32'h0000_0400;
    return t;
  endfunction

  task automatic drive();
    rst                = rst_i;
    ifc.hold           = hold_i;
    ifc.flush          = flush_i;
    ifc.id_valid       = cur.valid;
    ifc.id_reg_write   = cur.reg_write;
    ifc.id_mem_to_reg  = cur.mem_to_reg;
    ifc.id_mem_write   = cur.mem_write;
    ifc.id_alu_src     = cur.alu_src;
    ifc.id_reg_dst_rt  = cur.reg_dst_rt;
    ifc.id_is_shift    = cur.is_shift;
    ifc.id_is_jal      = cur.is_jal;
    ifc.id_alu_control = cur.alu_control;
    ifc.id_is_branch   = cur.is_branch;
    ifc.id_uses_rs     = cur.uses_rs;
    ifc.id_uses_rt     = cur.uses_rt;
    ifc.id_rs          = cur.rs;
    ifc.id_rt          = cur.rt;
    ifc.id_rd          = cur.rd;
    ifc.id_shamt       = cur.shamt;
    ifc.id_rs_data     = cur.rs_data;
    ifc.id_rt_data     = cur.rt_data;
    ifc.id_imm         = cur.imm;
    ifc.id_pc_plus4    = cur.pc4;
  endtask

  function automatic ex_t dut_ex();
    return '{ifc.ex_valid, ifc.ex_reg_write, ifc.ex_mem_to_reg, ifc.ex_mem_write,
             ifc.ex_alu_src, ifc.ex_is_shift, ifc.ex_is_jal, ifc.ex_alu_control,
             ifc.ex_rs, ifc.ex_rt, ifc.ex_write_reg, ifc.ex_shamt, ifc.ex_rs_data,
             ifc.ex_rt_data, ifc.ex_imm, ifc.ex_pc_plus4};
  endfunction

  // Stall rule: ID reads a nonzero register that the valid EX instruction
  // will write, and EX is a load or ID is a branch
  function automatic bit model_stall();
    bit reads_it;
    reads_it = (cur.uses_rs && cur.rs != 0 && cur.rs == m_ex.wr) ||
               (cur.uses_rt && cur.rt != 0 && cur.rt == m_ex.wr);
    return !rst_i && cur.valid && !flush_i && m_ex.valid && m_ex.reg_write && reads_it &&
           (m_ex.mem_to_reg || cur.is_branch);
  endfunction

  function automatic ex_t model_next(input bit s);
    ex_t n;
    n = '0;
    if (rst_i)                              n = '0;
    else if (hold_i)                        n = m_ex;
    else if (flush_i || s || !cur.valid)    n = '0;
    else begin
      n.valid       = 1'b1;
      n.reg_write   = cur.reg_write;
      n.mem_to_reg  = cur.mem_to_reg;
      n.mem_write   = cur.mem_write;
      n.alu_src     = cur.alu_src;
      n.is_shift    = cur.is_shift;
      n.is_jal      = cur.is_jal;
      n.alu_control = cur.alu_control;
      n.rs          = cur.rs;
      n.rt          = cur.rt;
      n.wr          = cur.is_jal ? 5'd31 : (cur.reg_dst_rt ? cur.rt : cur.rd);
      n.shamt       = cur.shamt;
      n.rs_data     = cur.rs_data;
      n.rt_data     = cur.rt_data;
      n.imm         = cur.imm;
      n.pc4         = cur.pc4;
    end
    return n;
  endfunction

  // Called at a falling edge: apply inputs, check stall, clock once, check state
  task automatic tick();
    ex_t nxt;
    bit  s;
    drive();
    #1;
    s = model_stall();
    chk("stall", 160'(ifc.stall), 160'(s));
    nxt = model_next(s);
    if (rst_i) begin
      m_stall_cnt = 0;
      m_bub_cnt   = 0;
    end else if (!hold_i) begin
      if (s) m_stall_cnt = m_stall_cnt + 1;
      if (flush_i || s || !cur.valid) m_bub_cnt = m_bub_cnt + 1;
    end
    @(posedge clk);
    #1;
    m_ex = nxt;
    chk("ex_bundle", 160'(dut_ex()), 160'(m_ex));
    chk("stall_cycles", 160'(stall_cycles), 160'(m_stall_cnt));
    chk("bubble_count", 160'(bubble_count), 160'(m_bub_cnt));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_i = 1; hold_i = 0; flush_i = 0; cur = '0;
    tick();
    rst_i = 0;
  endtask

  id_t  i_add, i_lw, i_addi7, i_beq7, i_jal, i_wr0, i_rd0, i_use5, i_rt5, i_nort5, i_beq31, i_beq5;
  vec_t vecs[8];

  initial begin
    i_add   = mk(1,0,0,1,1, 5'd1, 5'd2, 5'd3, 0,0);
    i_lw    = mk(1,1,0,1,0, 5'd4, 5'd5, 5'd0, 1,0);
    i_addi7 = mk(1,0,0,1,0, 5'd1, 5'd7, 5'd0, 1,0);
    i_beq7  = mk(0,0,1,1,1, 5'd7, 5'd0, 5'd0, 0,0);
    i_jal   = mk(1,0,0,0,0, 5'd0, 5'd0, 5'd0, 0,1);
    i_wr0   = mk(1,0,0,1,1, 5'd1, 5'd2, 5'd0, 0,0);
    i_rd0   = mk(1,0,0,1,1, 5'd0, 5'd0, 5'd4, 0,0);
    i_use5  = mk(1,0,0,1,1, 5'd5, 5'd0, 5'd6, 0,0);
    i_rt5   = mk(1,0,0,1,1, 5'd1, 5'd5, 5'd6, 0,0);
    i_nort5 = mk(1,0,0,1,0, 5'd1, 5'd5, 5'd0, 1,0);
    i_beq31 = mk(0,0,1,1,1, 5'd31, 5'd0, 5'd0, 0,0);
    i_beq5  = mk(0,0,1,1,1, 5'd5, 5'd0, 5'd0, 0,0);

    vecs[0] = '{i_lw,    i_use5,  1'b0, 1'b1, 5'd5};
    vecs[1] = '{i_addi7, i_beq7,  1'b0, 1'b1, 5'd7};
    vecs[2] = '{i_addi7, mk(1,0,0,1,1, 5'd7, 5'd1, 5'd8, 0,0), 1'b0, 1'b0, 5'd7};
    vecs[3] = '{i_wr0,   i_rd0,   1'b0, 1'b0, 5'd0};
    vecs[4] = '{i_lw,    i_use5,  1'b1, 1'b0, 5'd5};
    vecs[5] = '{i_lw,    i_rt5,   1'b0, 1'b1, 5'd5};
    vecs[6] = '{i_lw,    i_nort5, 1'b0, 1'b0, 5'd5};
    vecs[7] = '{i_jal,   i_beq31, 1'b0, 1'b1, 5'd31};

    rst_i = 1; hold_i = 0; flush_i = 0; cur = '0;
    m_ex = '0; m_stall_cnt = 0; m_bub_cnt = 0;
    drive();
    @(negedge clk);

    // Reset state, and stall suppressed while reset is high
    do_reset();
    rst_i = 1; cur = i_lw; tick();
    cur = i_use5; drive(); #1;
    chk("rst_stall", 160'(ifc.stall), 160'(0));
    tick();
    chk("rst_ex_valid", 160'(ifc.ex_valid), 160'(0));
    chk("rst_counters", 160'({stall_cycles, bubble_count}), 160'(0));
    rst_i = 0;

    // Vector table
    for (int v = 0; v < 8; v++) begin
      do_reset();
      cur = vecs[v].ex_in; tick();
      chk("vec_wr", 160'(ifc.ex_write_reg), 160'(vecs[v].exp_wr));
      cur = vecs[v].id_in; flush_i = vecs[v].flush;
      drive(); #1;
      chk("vec_stall", 160'(ifc.stall), 160'(vecs[v].exp_stall));
      tick();
      flush_i = 0;
    end

    // Straight-line capture
    do_reset();
    cur = i_add; tick();
    chk("add_capture", 160'({ifc.ex_valid, ifc.ex_reg_write, ifc.ex_write_reg, ifc.ex_rs_data}),
        160'({1'b1, 1'b1, 5'd3, 32'h1000_0001}));

    // Load-use: one stall cycle, then capture
    do_reset();
    cur = i_lw; tick();
    cur = i_use5; tick();
    chk("lu_counts", 160'({stall_cycles, bubble_count}), 160'({32'd1, 32'd1}));
    chk("lu_bubble", 160'(ifc.ex_valid), 160'(0));
    tick();
    chk("lu_capture", 160'({ifc.ex_valid, ifc.ex_write_reg}), 160'({1'b1, 5'd6}));

    // Load followed by dependent branch: only one stall cycle from this block
    do_reset();
    cur = i_lw; tick();
    cur = i_beq5; tick(); tick();
    chk("lb_stall_cycles", 160'(stall_cycles), 160'(1));

    // Hold during a load-use stall
    do_reset();
    cur = i_lw; tick();
    cur = i_use5; hold_i = 1;
    for (int k = 0; k < 3; k++) tick();
    chk("hold_frozen", 160'({ifc.stall, ifc.ex_write_reg, stall_cycles, bubble_count}),
        160'({1'b1, 5'd5, 32'd0, 32'd0}));
    hold_i = 0; tick(); tick();
    chk("hold_release", 160'({ifc.ex_valid, ifc.ex_write_reg, stall_cycles, bubble_count}),
        160'({1'b1, 5'd6, 32'd1, 32'd1}));

    // Flush beats stall, then reset while EX is valid
    do_reset();
    cur = i_lw; tick();
    cur = i_use5; flush_i = 1; tick();
    chk("flush_counts", 160'({stall_cycles, bubble_count}), 160'({32'd0, 32'd1}));
    flush_i = 0; cur = i_addi7; tick();
    rst_i = 1; tick(); rst_i = 0;
    chk("reset_mid", 160'({ifc.ex_valid, ifc.ex_write_reg, stall_cycles, bubble_count}), 160'(0));

    // Random run against the model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      cur = '0;
      cur.valid       = ($urandom_range(99) < 85);
      cur.reg_write   = $urandom_range(1);
      cur.mem_to_reg  = $urandom_range(1);
      cur.mem_write   = $urandom_range(1);
      cur.alu_src     = $urandom_range(1);
      cur.reg_dst_rt  = $urandom_range(1);
      cur.is_shift    = $urandom_range(1);
      cur.is_jal      = ($urandom_range(9) == 0);
      cur.alu_control = 5'($urandom_range(10));
      cur.is_branch   = $urandom_range(1);
      cur.uses_rs     = $urandom_range(1);
      cur.uses_rt     = $urandom_range(1);
      cur.rs          = 5'($urandom_range(7));
      cur.rt          = 5'($urandom_range(7));
      cur.rd          = 5'($urandom_range(7));
      cur.shamt       = 5'($urandom);
      cur.rs_data     = $urandom;
      cur.rt_data     = $urandom;
      cur.imm         = $urandom;
      cur.pc4         = $urandom;
      hold_i  = ($urandom_range(99) < 10);
      flush_i = ($urandom_range(99) < 8);
      rst_i   = ($urandom_range(99) < 2);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the MIPS CPU, directly downstream of the decode control unit.
- Captures the control unit's signals together with the decoded operands each cycle and presents them to EX.
- Detects load-use hazards and branch-in-ID operand hazards, stalls PC/IF-ID, and injects bubbles.
- Supports external hold (memory wait) and flush, and keeps stall/bubble performance counters.

Parameters:
- DATA_W, 32, operand/PC/immediate width
- RA_W, 5, register address width
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_reg_write, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_dst_rt, id_is_shift, id_is_jal  in  1 each  control unit outputs
- id_alu_control  in  5  control unit ALU code
- id_is_branch  in  1  ID instruction is BEQ/BNE/JR (operands needed in ID)
- id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs/rt
- id_rs, id_rt, id_rd  in  RA_W each  register fields
- id_shamt  in  5  shift amount
- id_rs_data, id_rt_data, id_imm, id_pc_plus4  in  DATA_W each  operands, extended immediate, PC+4
- hold  in  1  freeze whole pipeline this cycle
- flush  in  1  discard the ID instruction
- stall  out  1  combinational; hold PC and IF/ID
- ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_is_shift, ex_is_jal  out  1 each  registered
- ex_alu_control  out  5  registered
- ex_rs, ex_rt, ex_write_reg  out  RA_W each  registered
- ex_shamt  out  5  registered
- ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus4  out  DATA_W each  registered
- stall_cycles, bubble_count  out  CNT_W each  performance counters

Behaviour:
- Reset: all ex_* outputs are 0 (ex_valid=0, i.e. a bubble); both counters are 0. stall is 0 while reset is high.
- Destination match:
  - dep_rs = id_uses_rs and id_rs != 0 and id_rs == ex_write_reg.
  - dep_rt is defined the same way for rt.
  - dep = ex_valid and ex_reg_write and (dep_rs or dep_rt).
- Hazard terms:
  - load_use = dep and ex_mem_to_reg.
  - branch_dep = dep and id_is_branch.
  - stall = id_valid and not flush and (load_use or branch_dep).
- Write register, computed at capture: 31 if id_is_jal; else id_rt if id_reg_dst_rt; else id_rd.
- Per rising edge, priority reset > hold > flush > stall > capture:
  - hold: all registers keep their value; counters do not change.
  - flush, stall, or id_valid=0: load a bubble. A bubble is every ex_* output 0, including the data fields and ex_write_reg=0.
  - capture: copy all id_* fields; ex_valid=1.
- Latency: 1 cycle from ID inputs to ex_* outputs. No combinational path from id_* to ex_*.
- Load followed by a branch that uses the load result: 2 stall cycles. The first is load_use; the second is branch_dep against the following bubble, which does not match. So the second cycle comes from the MEM-stage path, outside this block; this block itself asserts stall for exactly 1 cycle. Document this limit; it is not a bug.
- Counters:
  - stall_cycles increments on every non-hold cycle with stall=1.
  - bubble_count increments on every non-hold edge that loads a bubble.
  - Both wrap modulo 2^CNT_W.
- flush together with a hazard: flush wins; stall=0 and a bubble is loaded.
- Register 0 is never a dependency.
- hold with stall=1: stall stays asserted and state is frozen.
- reset asserted mid-stall: the next edge yields the reset state; the stall is dropped.

Decomposition:
- Shared package cpu_pkg:
  - ALU control code localparams, matching the control unit's encoding.
  - REG_RA = 31.
  - Bubble constant for the control bundle.
- One sub-module, hazard_detect: purely combinational; computes dep, load_use, branch_dep and stall.
- Registers and counters stay in id_ex_stage.

Test Plan:
- Straight-line capture: ADD with rs=1, rt=2, rd=3, id_valid=1 -> next cycle ex_valid=1, ex_write_reg=3, ex_reg_write=1, ex_rs_data equals input; stall=0.
- Load-use: EX holds LW with rt=5 (write_reg 5, mem_to_reg=1) and ID holds ADD with rs=5 -> stall=1 for 1 cycle, bubble loaded, bubble_count=1, stall_cycles=1; ADD captured the following cycle.
- Branch dependency: EX holds ADDI writing r7 and ID holds BEQ with rs=7 -> stall=1; after the bubble, stall=0 and BEQ captured.
- JAL and r0: JAL captured -> ex_write_reg=31. Separately, EX writes r0 (ex_write_reg=0) and ID reads r0 -> stall=0.
- Hold priority: during a load-use stall, assert hold for 3 cycles -> ex_* unchanged, counters unchanged; after release, stall resolves exactly as without hold.
- Flush vs stall, then reset: flush and load-use in the same cycle -> stall=0, bubble loaded. Then reset while EX is valid -> all ex_*=0 and counters=0 on the next edge.
